video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter X_RESOLUTION, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT_PORCH, default 16, H_SYNC default 96, H_BACK_PORCH default 48: blanking beats per line.
REQ-003 SHALL have parameter Y_RESOLUTION, default 480, active lines per frame.
REQ-004 SHALL have parameter V_FRONT_PORCH, default 10, V_SYNC default 2, V_BACK_PORCH default 33: blanking lines per frame.
REQ-005 SHALL have parameter SYNC_ACTIVE_HIGH, default 0, sync polarity (0 = active-low).
REQ-006 SHALL have port clk_i, input, 1, the single clock.
REQ-007 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port enable_i, input, 1, run request.
REQ-009 SHALL have port ready_i, input, 1, downstream accepts the current beat.
REQ-010 SHALL have port valid_o, output, 1, current beat is valid.
REQ-011 SHALL have ports hsync_o, vsync_o, vde_o, outputs, 1 each: sync and data-enable of the current beat.
REQ-012 SHALL have ports x_o, y_o, outputs, 32 each: horizontal and vertical beat position, including blanking.
REQ-013 SHALL have port frame_start_o, output, 1, high on beat (0,0) only.

Function
REQ-014 H_TOTAL = X_RESOLUTION+H_FRONT_PORCH+H_SYNC+H_BACK_PORCH; V_TOTAL is formed likewise; internal counters SHALL be $clog2(total) bits wide, zero-extended onto x_o/y_o.
REQ-015 A beat SHALL transfer iff valid_o && ready_i; position SHALL advance by exactly one beat per transfer.
REQ-016 While valid_o && !ready_i, all outputs SHALL hold stable.
REQ-017 Horizontal phase SHALL run in order ACTIVE (x < X_RESOLUTION), FRONT, SYNC, BACK; vertical phase SHALL run in the same order over lines.
REQ-018 x SHALL wrap H_TOTAL-1 -> 0 and increment y on the same transfer; y SHALL wrap V_TOTAL-1 -> 0 on the transfer that wraps x.
REQ-019 vde_o SHALL be 1 iff both phases are ACTIVE; hsync_o SHALL be at its active level iff the horizontal phase is SYNC; vsync_o SHALL be at its active level for every beat of lines in the vertical SYNC phase.
REQ-020 Run control SHALL use two states, IDLE and RUN: IDLE -> RUN when enable_i=1, with valid_o=1 on the next cycle at (0,0).
REQ-021 enable_i=0 in RUN SHALL take effect only at the frame boundary: after the transfer of beat (H_TOTAL-1, V_TOTAL-1), the block SHALL enter IDLE with valid_o=0 and position (0,0).
REQ-022 If enable_i=1 at the frame boundary, the next beat SHALL be (0,0) with no bubble cycle.
REQ-023 In IDLE, valid_o, vde_o and frame_start_o SHALL be 0 and syncs SHALL be inactive.

Reset
REQ-024 rst_i=1 at a clock edge SHALL force IDLE, x=y=0, valid_o=0, vde_o=0, frame_start_o=0, syncs inactive, from the next cycle, regardless of the current phase or handshake.
REQ-025 Reset SHALL override enable_i and ready_i in the same cycle.

Structure
REQ-026 Package video_timing_pkg SHALL hold the phase enum (ACTIVE, FRONT, SYNC, BACK) and the run-state enum (IDLE, RUN).
REQ-027 Sub-module timing_axis_counter (parameters: active, front, sync, back lengths; inputs: step, clear; outputs: count, phase, wrap) SHALL be instantiated twice, once per axis; the vertical step SHALL be horizontal wrap && transfer.

Verification (X_RES=4, HFP=1, HS=2, HBP=1, Y_RES=3, VFP=1, VS=1, VBP=1; H_TOTAL=8, V_TOTAL=6)
REQ-028 Reset release, enable=1, ready=1 -> valid_o=1 one cycle later; first beat x=0, y=0, vde=1, frame_start=1; vde high for x=0..3, hsync active for x=5..6.
REQ-029 Free run over one frame -> exactly 48 transfers and 12 vde beats; vsync active on all 8 beats of y=4; frame_start exactly once.
REQ-030 ready=0 for 3 cycles at x=2, y=0 -> x_o=2 and all outputs frozen for 3 cycles; x=3 on the first cycle after ready returns.
REQ-031 enable=0 at transfer 10 -> transfers continue through beat (7,5); then valid_o=0 and x=y=0; re-enable -> (0,0) with frame_start=1.
REQ-032 rst_i pulse at x=6, y=4 with ready=0 -> next cycle valid_o=0, vsync and hsync inactive, x=y=0.
REQ-033 SYNC_ACTIVE_HIGH=1 rerun of REQ-028 -> hsync_o=1 only at x=5..6.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared types for the video timing generator.
// Axis phases, run states and a counter width helper.
package video_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } phase_t;

    typedef enum logic {
        IDLE,
        RUN
    } run_state_t;

    // Counter width for an axis of the given total length
    function automatic int axis_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One timing axis: beat/line counter with phase decode.
// wrap flags the last position so the caller can chain axes.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = 640,
    parameter int FRONT_LEN  = 16,
    parameter int SYNC_LEN   = 96,
    parameter int BACK_LEN   = 48,
    localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN,
    localparam int W     = axis_width(TOTAL)
) (
    input  logic         clk,
    input  logic         step,
    input  logic         clear,
    output logic [W-1:0] count,
    output phase_t       phase,
    output logic         wrap
);

    localparam logic [W-1:0] FRONT_START = W'(ACTIVE_LEN);
    localparam logic [W-1:0] SYNC_START  = W'(ACTIVE_LEN + FRONT_LEN);
    localparam logic [W-1:0] BACK_START  = W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);
    localparam logic [W-1:0] LAST        = W'(TOTAL - 1);

    assign wrap = (count == LAST);

    // Phase decode from the current position
    always_comb begin
        phase = BACK;
        if (count < FRONT_START) begin
            phase = ACTIVE;
        end else if (count < SYNC_START) begin
            phase = FRONT;
        end else if (count < BACK_START) begin
            phase = SYNC;
        end
    end

    // Advance one position per step, wrapping at the last one
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator with valid/ready beat handshake.
// Stopping is deferred to the frame boundary.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int X_RESOLUTION     = 640,
    parameter int H_FRONT_PORCH    = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK_PORCH     = 48,
    parameter int Y_RESOLUTION     = 480,
    parameter int V_FRONT_PORCH    = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK_PORCH     = 33,
    parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        vde_o,
    output logic [31:0] x_o,
    output logic [31:0] y_o,
    output logic        frame_start_o
);

    localparam int H_TOTAL = X_RESOLUTION + H_FRONT_PORCH
                           + H_SYNC + H_BACK_PORCH;
    localparam int V_TOTAL = Y_RESOLUTION + V_FRONT_PORCH
                           + V_SYNC + V_BACK_PORCH;
    localparam int H_W = axis_width(H_TOTAL);
    localparam int V_W = axis_width(V_TOTAL);

    run_state_t     state;
    logic           valid_q;
    logic           transfer;
    logic           frame_end;
    logic [H_W-1:0] h_count;
    logic [V_W-1:0] v_count;
    phase_t         h_phase;
    phase_t         v_phase;
    logic           h_wrap;
    logic           v_wrap;
    logic           hsync_act;
    logic           vsync_act;

    assign transfer  = valid_q && ready_i;
    assign frame_end = transfer && h_wrap && v_wrap;

    timing_axis_counter #(
        .ACTIVE_LEN (X_RESOLUTION),
        .FRONT_LEN  (H_FRONT_PORCH),
        .SYNC_LEN   (H_SYNC),
        .BACK_LEN   (H_BACK_PORCH)
    ) u_h_axis (
        .clk   (clk_i),
        .step  (transfer),
        .clear (rst_i),
        .count (h_count),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    timing_axis_counter #(
        .ACTIVE_LEN (Y_RESOLUTION),
        .FRONT_LEN  (V_FRONT_PORCH),
        .SYNC_LEN   (V_SYNC),
        .BACK_LEN   (V_BACK_PORCH)
    ) u_v_axis (
        .clk   (clk_i),
        .step  (transfer && h_wrap),
        .clear (rst_i),
        .count (v_count),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

    // Run control: start at once, stop only after the last beat of a frame
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable_i) begin
                        state   <= RUN;
                        valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (frame_end && !enable_i) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign hsync_act = valid_q && (h_phase == SYNC);
    assign vsync_act = valid_q && (v_phase == SYNC);

    assign valid_o       = valid_q;
    assign hsync_o       = SYNC_ACTIVE_HIGH ? hsync_act : !hsync_act;
    assign vsync_o       = SYNC_ACTIVE_HIGH ? vsync_act : !vsync_act;
    assign vde_o         = valid_q && (h_phase == ACTIVE)
                                   && (v_phase == ACTIVE);
    assign frame_start_o = valid_q && (h_count == '0) && (v_count == '0);
    assign x_o           = 32'(h_count);
    assign y_o           = 32'(v_count);

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a tiny 8x6 raster.
// A reference model pushes expected beats; tests pop and compare.
module tb_video_timing_gen;

    localparam int XR  = 4;
    localparam int HFP = 1;
    localparam int HS  = 2;
    localparam int HBP = 1;
    localparam int YR  = 3;
    localparam int VFP = 1;
    localparam int VS  = 1;
    localparam int VBP = 1;
    localparam int HT  = XR + HFP + HS + HBP;
    localparam int VT  = YR + VFP + VS + VBP;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        ready;

    logic        valid_o, hsync_o, vsync_o, vde_o, frame_start_o;
    logic [31:0] x_o, y_o;
    logic        valid_h, hsync_h, vsync_h, vde_h, frame_start_h;
    logic [31:0] x_h, y_h;

    typedef struct packed {
        logic        valid;
        logic        hsync;
        logic        vsync;
        logic        vde;
        logic        fs;
        logic [31:0] x;
        logic [31:0] y;
    } beat_t;

    beat_t obs;
    beat_t e;
    beat_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    bit m_run = 1'b0;
    int mx    = 0;
    int my    = 0;

    assign obs = {valid_o, hsync_o, vsync_o, vde_o,
                  frame_start_o, x_o, y_o};

    always #5 clk = ~clk;

    video_timing_gen #(
        .X_RESOLUTION(XR), .H_FRONT_PORCH(HFP),
        .H_SYNC(HS), .H_BACK_PORCH(HBP),
        .Y_RESOLUTION(YR), .V_FRONT_PORCH(VFP),
        .V_SYNC(VS), .V_BACK_PORCH(VBP),
        .SYNC_ACTIVE_HIGH(1'b0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .ready_i(ready),
        .valid_o(valid_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .vde_o(vde_o), .x_o(x_o), .y_o(y_o),
        .frame_start_o(frame_start_o)
    );

    video_timing_gen #(
        .X_RESOLUTION(XR), .H_FRONT_PORCH(HFP),
        .H_SYNC(HS), .H_BACK_PORCH(HBP),
        .Y_RESOLUTION(YR), .V_FRONT_PORCH(VFP),
        .V_SYNC(VS), .V_BACK_PORCH(VBP),
        .SYNC_ACTIVE_HIGH(1'b1)
    ) dut_hi (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .ready_i(ready),
        .valid_o(valid_h), .hsync_o(hsync_h), .vsync_o(vsync_h),
        .vde_o(vde_h), .x_o(x_h), .y_o(y_h),
        .frame_start_o(frame_start_h)
    );

    function automatic beat_t model_beat();
        beat_t b;
        logic  hact, vact;
        hact    = m_run && mx >= XR + HFP && mx < XR + HFP + HS;
        vact    = m_run && my >= YR + VFP && my < YR + VFP + VS;
        b.valid = m_run;
        b.hsync = !hact;
        b.vsync = !vact;
        b.vde   = m_run && mx < XR && my < YR;
        b.fs    = m_run && mx == 0 && my == 0;
        b.x     = 32'(mx);
        b.y     = 32'(my);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_run = 1'b0;
            mx    = 0;
            my    = 0;
        end else if (!m_run) begin
            if (enable) m_run = 1'b1;
        end else if (ready) begin
            if (mx == HT - 1) begin
                mx = 0;
                if (my == VT - 1) begin
                    my = 0;
                    if (!enable) m_run = 1'b0;
                end else begin
                    my = my + 1;
                end
            end else begin
                mx = mx + 1;
            end
        end
        exp_q.push_back(model_beat());
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b0;
        ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rst = 1'b0;
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset[%0d] got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_first_beat();
        enable = 1'b1;
        ready  = 1'b1;
        for (int i = 0; i < HT; i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL first_beat[%0d] got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_free_run();
        int n_xfer, n_vde, n_vs, n_fs;
        n_xfer = 0; n_vde = 0; n_vs = 0; n_fs = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        void'(exp_q.pop_front());
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL free_run_start got=%h want=%h", obs, e);
        end
        for (int i = 0; i < HT * VT; i++) begin
            if (valid_o && ready) n_xfer++;
            if (valid_o && vde_o) n_vde++;
            if (valid_o && !vsync_o) n_vs++;
            if (valid_o && frame_start_o) n_fs++;
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL free_run[%0d] got=%h want=%h", i, obs, e);
            end
        end
        n_checks++;
        if (n_xfer !== 48) begin
            n_fail++;
            $display("FAIL transfers got=%0d want=48", n_xfer);
        end
        n_checks++;
        if (n_vde !== 12) begin
            n_fail++;
            $display("FAIL vde_beats got=%0d want=12", n_vde);
        end
        n_checks++;
        if (n_vs !== 8) begin
            n_fail++;
            $display("FAIL vsync_beats got=%0d want=8", n_vs);
        end
        n_checks++;
        if (n_fs !== 1) begin
            n_fail++;
            $display("FAIL frame_starts got=%0d want=1", n_fs);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL stall_pre[%0d] got=%h want=%h", i, obs, e);
            end
        end
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e || x_o !== 32'd2) begin
                n_fail++;
                $display("FAIL stall[%0d] got=%h want=%h", i, obs, e);
            end
        end
        ready = 1'b1;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || x_o !== 32'd3) begin
            n_fail++;
            $display("FAIL stall_release got=%h want=%h", obs, e);
        end
    endtask

    task automatic test_enable_drop();
        int n_xfer;
        int guard;
        n_xfer = 0;
        rst    = 1'b1;
        enable = 1'b1;
        ready  = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        for (int i = 0; i < 10; i++) begin
            if (valid_o && ready) n_xfer++;
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL drop_pre[%0d] got=%h want=%h", i, obs, e);
            end
        end
        enable = 1'b0;
        guard  = 0;
        while (valid_o && guard < 100) begin
            n_xfer++;
            guard++;
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL drop[%0d] got=%h want=%h", guard, obs, e);
            end
        end
        n_checks++;
        if (n_xfer !== 48 || guard >= 100) begin
            n_fail++;
            $display("FAIL drop_transfers got=%0d want=48", n_xfer);
        end
        n_checks++;
        if (valid_o !== 1'b0 || x_o !== 0 || y_o !== 0) begin
            n_fail++;
            $display("FAIL drop_idle got v=%b x=%0d y=%0d want v=0 x=0 y=0",
                     valid_o, x_o, y_o);
        end
        enable = 1'b1;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || frame_start_o !== 1'b1) begin
            n_fail++;
            $display("FAIL re_enable got=%h want=%h", obs, e);
        end
    endtask

    task automatic test_reset_midframe();
        int guard;
        guard = 0;
        while (!(mx == 6 && my == 4) && guard < 100) begin
            guard++;
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL mid_run[%0d] got=%h want=%h", guard, obs, e);
            end
        end
        if (guard >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL mid_reach got=(%0d,%0d) want=(6,4)", mx, my);
        end
        ready = 1'b0;
        rst   = 1'b1;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || valid_o !== 1'b0 || vsync_o !== 1'b1
            || hsync_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset got=%h want=%h", obs, e);
        end
        rst   = 1'b0;
        ready = 1'b1;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL mid_restart got=%h want=%h", obs, e);
        end
    endtask

    task automatic test_polarity();
        logic want_hs;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_front());
        for (int i = 0; i < HT; i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL pol_main[%0d] got=%h want=%h", i, obs, e);
            end
            want_hs = m_run && mx >= 5 && mx <= 6;
            n_checks++;
            if (hsync_h !== want_hs || x_h !== 32'(mx)) begin
                n_fail++;
                $display("FAIL pol_hsync[%0d] got hs=%b x=%0d want hs=%b x=%0d",
                         i, hsync_h, x_h, want_hs, mx);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        ready  = 1'b1;
        test_reset();
        test_first_beat();
        test_free_run();
        test_stall();
        test_enable_drop();
        test_reset_midframe();
        test_polarity();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
